clk_div_prog: RTL and testbench

CLK_DIV_PROG -- requirements
Module: clk_div_prog

---
 rtl/clk_div_prog.sv | 110 +++++++++++
 tb/tb_clk_div_prog.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// Programmable multi-channel clock divider; new divisor/threshold settings are
// shadowed and take effect on the next wrap. Optional macro: CLKDIV_TICK_EN builds the tick outputs.
module clk_div_prog #(
  parameter int N  = 24,
  parameter int CH = 2,
  parameter int M  = 10000000,
  localparam int CW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CH-1:0] en,
  input  logic          load,
  input  logic [CW-1:0] load_ch,
  input  logic [N-1:0]  load_div,
  input  logic [N-1:0]  load_hi,
  output logic [CH-1:0] q,
  output logic [CH-1:0] tick,
  output logic          load_err
);

  localparam logic [N-1:0] RST_DIV = N'(M);
  localparam logic [N-1:0] RST_HI  = N'(M / 2);
  localparam logic [CW:0]  CH_LIM  = (CW + 1)'(CH);

  logic [N-1:0]  cnt_q    [CH];
  logic [N-1:0]  cnt_d    [CH];
  logic [N-1:0]  actDiv_q [CH];
  logic [N-1:0]  actDiv_d [CH];
  logic [N-1:0]  actHi_q  [CH];
  logic [N-1:0]  actHi_d  [CH];
  logic [N-1:0]  shDiv_q  [CH];
  logic [N-1:0]  shDiv_d  [CH];
  logic [N-1:0]  shHi_q   [CH];
  logic [N-1:0]  shHi_d   [CH];
  logic [CH-1:0] pend_q;
  logic [CH-1:0] pend_d;
  logic          loadErr_q;
  logic          loadErr_d;
  logic          loadOk;
  logic [CH-1:0] wrap;

  // A pending setting is promoted at a wrap, or at once while the channel is idle.
  // The promotion reads the shadow before this edge's load, so a load on a wrap waits a period.
  always_comb begin
    loadOk    = load && ({1'b0, load_ch} < CH_LIM) && (load_div != '0);
    loadErr_d = load && !loadOk;
    cnt_d     = cnt_q;
    actDiv_d  = actDiv_q;
    actHi_d   = actHi_q;
    shDiv_d   = shDiv_q;
    shHi_d    = shHi_q;
    pend_d    = pend_q;
    wrap      = '0;
    for (int i = 0; i < CH; i++) begin
      wrap[i] = (cnt_q[i] == actDiv_q[i]);
      if (!en[i] || wrap[i]) begin
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + N'(1);
      end
      if (pend_q[i] && (wrap[i] || !en[i])) begin
        actDiv_d[i] = shDiv_q[i];
        actHi_d[i]  = shHi_q[i];
        pend_d[i]   = 1'b0;
      end
      if (loadOk && (load_ch == CW'(i))) begin
        shDiv_d[i] = load_div;
        shHi_d[i]  = load_hi;
        pend_d[i]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CH; i++) begin
        cnt_q[i]    <= '0;
        actDiv_q[i] <= RST_DIV;
        actHi_q[i]  <= RST_HI;
        shDiv_q[i]  <= RST_DIV;
        shHi_q[i]   <= RST_HI;
      end
      pend_q    <= '0;
      loadErr_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      actDiv_q  <= actDiv_d;
      actHi_q   <= actHi_d;
      shDiv_q   <= shDiv_d;
      shHi_q    <= shHi_d;
      pend_q    <= pend_d;
      loadErr_q <= loadErr_d;
    end
  end

  // Outputs are pure decodes of the counters; reset gating keeps them low even if M/2 is 0.
  always_comb begin
    q    = '0;
    tick = '0;
    for (int i = 0; i < CH; i++) begin
      q[i] = !reset && en[i] && (cnt_q[i] >= actHi_q[i]);
`ifdef CLKDIV_TICK_EN
      tick[i] = !reset && en[i] && wrap[i];
`endif
    end
  end

  assign load_err = loadErr_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog (N=8, CH=2, M=9) plus a CH=3 instance for out-of-range channel loads.
// Tick expectations follow CLKDIV_TICK_EN so the same bench covers both builds.
module tb_clk_div_prog;

  localparam int N  = 8;
  localparam int CH = 2;
  localparam int M  = 9;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] en;
  logic       load;
  logic [0:0] load_ch;
  logic [7:0] load_div;
  logic [7:0] load_hi;
  logic [1:0] q;
  logic [1:0] tick;
  logic       load_err;

  logic [2:0] en3;
  logic       load3;
  logic [1:0] ch3;
  logic [7:0] div3;
  logic [7:0] hi3;
  logic [2:0] q3;
  logic [2:0] tick3;
  logic       err3;

  typedef struct packed {
    logic [1:0] q;
    logic [1:0] tick;
    logic       err;
  } exp_t;

  exp_t sb[$];
  exp_t mon;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   ph[2];
  int   curP[2];
  int   curH[2];
  int   nxtP[2];
  int   nxtH[2];
  bit   nxtV[2];
  bit   errPrev;

  clk_div_prog #(.N(N), .CH(CH), .M(M)) dut (
    .clk(clk), .reset(reset), .en(en), .load(load), .load_ch(load_ch),
    .load_div(load_div), .load_hi(load_hi), .q(q), .tick(tick), .load_err(load_err)
  );

  clk_div_prog #(.N(N), .CH(3), .M(M)) dut3 (
    .clk(clk), .reset(reset), .en(en3), .load(load3), .load_ch(ch3),
    .load_div(div3), .load_hi(hi3), .q(q3), .tick(tick3), .load_err(err3)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got %0h, expected %0h", tag, cyc, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int c = 0; c < 2; c++) begin
      ph[c]   = 0;
      curP[c] = M;
      curH[c] = M / 2;
      nxtV[c] = 1'b0;
    end
    errPrev = 1'b0;
  endtask

  task automatic resetCycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      reset = 1'b1;
      load  = 1'b0;
      sb.push_back('0);
      modelReset();
      cyc++;
    end
  endtask

  // One clock cycle of stimulus; the expected outputs of that cycle are queued.
  task automatic applyStimulus(input logic [1:0] enV, input bit ld, input int ch, input int div, input int hi);
    exp_t e;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    en       = enV;
    load     = ld;
    load_ch  = ch[0];
    load_div = div[7:0];
    load_hi  = hi[7:0];
    e     = '0;
    e.err = errPrev;
    for (int c = 0; c < 2; c++) begin
      e.q[c] = enV[c] && (ph[c] >= curH[c]);
`ifdef CLKDIV_TICK_EN
      e.tick[c] = enV[c] && (ph[c] == curP[c]);
`endif
    end
    sb.push_back(e);
    for (int c = 0; c < 2; c++) begin
      if (enV[c] && (ph[c] != curP[c])) begin
        ph[c]++;
      end else begin
        ph[c] = 0;
        if (nxtV[c]) begin
          curP[c] = nxtP[c];
          curH[c] = nxtH[c];
          nxtV[c] = 1'b0;
        end
      end
    end
    errPrev = ld && (div == 0);
    if (ld && (div != 0)) begin
      nxtP[ch] = div;
      nxtH[ch] = hi;
      nxtV[ch] = 1'b1;
    end
    cyc++;
  endtask

  task automatic idle(input logic [1:0] enV, input int n);
    for (int k = 0; k < n; k++) applyStimulus(enV, 1'b0, 0, 0, 0);
  endtask

  task automatic runUntil(input int c, input int target, input logic [1:0] enV);
    int k;
    k = 0;
    while ((ph[c] != target) && (k < 40)) begin
      applyStimulus(enV, 1'b0, 0, 0, 0);
      k++;
    end
    if (ph[c] != target) checkOutput("reach_phase", 32'(ph[c]), 32'(target));
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon = sb.pop_front();
      checkOutput("q", 32'(q), 32'(mon.q));
      checkOutput("tick", 32'(tick), 32'(mon.tick));
      checkOutput("load_err", 32'(load_err), 32'(mon.err));
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset = 1'b1; en = '0; load = 1'b0; load_ch = '0; load_div = '0; load_hi = '0;
    en3 = '0; load3 = 1'b0; ch3 = '0; div3 = '0; hi3 = '0;
    modelReset();
    resetCycles(3);

    // Default divider: period 10, high 6; channel 1 idle
    idle(2'b01, 25);

    // Mid-period load only takes effect after the current period ends
    runUntil(0, 5, 2'b01);
    applyStimulus(2'b01, 1'b1, 0, 3, 2);
    idle(2'b01, 16);

    // Load on the wrap cycle, then overwrite before the next wrap; channel 1 runs alongside
    runUntil(0, 3, 2'b11);
    applyStimulus(2'b11, 1'b1, 0, 7, 3);
    runUntil(0, 1, 2'b11);
    applyStimulus(2'b11, 1'b1, 0, 5, 2);
    idle(2'b11, 20);

    // Rejected zero divisor, then a load to a disabled channel applied immediately
    applyStimulus(2'b11, 1'b1, 0, 0, 1);
    idle(2'b11, 3);
    applyStimulus(2'b01, 1'b1, 1, 2, 1);
    idle(2'b01, 2);
    idle(2'b11, 10);
    idle(2'b00, 3);
    idle(2'b11, 8);

    // Reset mid-period with a pending load discards it
    resetCycles(2);
    runUntil(0, 3, 2'b01);
    applyStimulus(2'b01, 1'b1, 0, 2, 1);
    runUntil(0, 7, 2'b01);
    resetCycles(2);
    idle(2'b11, 25);

    for (int k = 0; (k < 5) && (sb.size() > 0); k++) @(negedge clk);
    #1;
    checkOutput("sb_drain", 32'(sb.size()), 32'd0);

    // Out-of-range channel index on a three-channel instance
    @(posedge clk); #1;
    load3 = 1'b1; ch3 = 2'd3; div3 = 8'd5; hi3 = 8'd2;
    @(posedge clk); #1;
    load3 = 1'b0;
    @(negedge clk);
    checkOutput("err3_oob", 32'(err3), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("err3_clear", 32'(err3), 32'd0);
    @(posedge clk); #1;
    load3 = 1'b1; ch3 = 2'd2; div3 = 8'd5;
    @(posedge clk); #1;
    load3 = 1'b0;
    @(negedge clk);
    checkOutput("err3_valid", 32'(err3), 32'd0);
    @(posedge clk); #1;
    load3 = 1'b1; ch3 = 2'd2; div3 = 8'd0;
    @(posedge clk); #1;
    load3 = 1'b0;
    @(negedge clk);
    checkOutput("err3_zero", 32'(err3), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
